hub_router: RTL

- Central switch of the Arduino hub. Collects the 4-bit packets {dest[1:0], data[1:0]} that each arduino node drives on its `out` port.
- Arbitrates between nodes round-robin and buffers the packets in a small FIFO.
- Delivers each packet's 2-bit data to the destination node's `in` port, one packet per delivery slot.
- Runs on clock50. Node outputs come from a divided clock, so they are treated as asynchronous.

---
 rtl/hub_router.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/hub_router.sv
// Central switch of the Arduino hub: synchronises node packets, arbitrates round-robin
// into a small FIFO and delivers one packet per slot to the destination node.
module hub_router #(
   parameter int FIFO_DEPTH = 4,
   parameter int SLOT_DIV   = 25000000
) (
   input  logic        clock50,
   input  logic        reset_n,
   input  logic [15:0] node_out,
   output logic [7:0]  node_in,
   output logic [3:0]  hub_display,
   output logic [2:0]  fifo_level,
   output logic [7:0]  drop_count
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = (SLOT_DIV > 1) ? $clog2(SLOT_DIV) : 1;
   localparam logic [2:0]    FULL_LVL  = 3'(FIFO_DEPTH);
   localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT_DIV - 1);

   logic [15:0]   sync_a;
   logic [15:0]   sync_b;
   logic [15:0]   hist;
   logic [3:0]    pend;
   logic [1:0]    pend_dest [4];
   logic [1:0]    pend_data [4];
   logic [1:0]    rr_ptr;
   logic [CW-1:0] slot_cnt;
   logic          slot_tick;

   logic [5:0]    fifo_mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [2:0]    level;
   logic          fifo_full;
   logic          fifo_empty;
   logic [5:0]    head;

   logic          pop;
   logic          push;
   logic          grant_found;
   logic [1:0]    grant_idx;
   logic [3:0]    grant_clr;
   logic [3:0]    req_new;
   logic [3:0]    req_drop;
   logic [3:0]    req_take;
   logic [2:0]    drop_inc;
   logic [8:0]    drop_sum;

   assign slot_tick  = (slot_cnt == SLOT_LAST);
   assign fifo_full  = (level == FULL_LVL);
   assign fifo_empty = (level == 3'd0);
   assign head       = fifo_mem[rd_ptr];
   assign pop        = slot_tick && !fifo_empty;
   assign push       = grant_found && (!fifo_full || pop);
   assign grant_clr  = push ? (4'b0001 << grant_idx) : 4'b0000;
   assign fifo_level = level;

   always_comb begin
      grant_found = 1'b0;
      grant_idx   = rr_ptr;
      for (int k = 0; k < 4; k++) begin
         if (!grant_found && pend[rr_ptr + 2'(k)]) begin
            grant_found = 1'b1;
            grant_idx   = rr_ptr + 2'(k);
         end
      end
   end

   // A flag being granted this cycle is free again, so a packet arriving now is accepted.
   always_comb begin
      req_new  = '0;
      req_drop = '0;
      req_take = '0;
      for (int i = 0; i < 4; i++) begin
         req_new[i] = (sync_b[4*i +: 2] != 2'b00) && (sync_b[4*i +: 4] != hist[4*i +: 4]);
         if (req_new[i]) begin
            if ((sync_b[4*i+2 +: 2] == 2'(i)) || (pend[i] && !grant_clr[i]))
               req_drop[i] = 1'b1;
            else
               req_take[i] = 1'b1;
         end
      end
   end

   assign drop_inc = {2'b00, req_drop[0]} + {2'b00, req_drop[1]} +
                     {2'b00, req_drop[2]} + {2'b00, req_drop[3]};
   assign drop_sum = {1'b0, drop_count} + {6'b0, drop_inc};

   always_ff @(posedge clock50 or negedge reset_n) begin
      if (!reset_n) begin
         sync_a   <= '0;
         sync_b   <= '0;
         hist     <= '0;
         pend     <= '0;
         rr_ptr   <= '0;
         slot_cnt <= '0;
         for (int i = 0; i < 4; i++) begin
            pend_dest[i] <= '0;
            pend_data[i] <= '0;
         end
      end else begin
         sync_a   <= node_out;
         sync_b   <= sync_a;
         hist     <= sync_b;
         slot_cnt <= slot_tick ? '0 : slot_cnt + CW'(1);
         if (push)
            rr_ptr <= grant_idx + 2'd1;
         for (int i = 0; i < 4; i++) begin
            if (req_take[i]) begin
               pend[i]      <= 1'b1;
               pend_dest[i] <= sync_b[4*i+2 +: 2];
               pend_data[i] <= sync_b[4*i +: 2];
            end else if (grant_clr[i]) begin
               pend[i] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clock50) begin
      if (push)
         fifo_mem[wr_ptr] <= {grant_idx, pend_dest[grant_idx], pend_data[grant_idx]};
   end

   always_ff @(posedge clock50 or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         level       <= '0;
         node_in     <= '0;
         hub_display <= '0;
         drop_count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PW'(1);
         if (pop)
            rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   level <= level + 3'd1;
            2'b01:   level <= level - 3'd1;
            default: level <= level;
         endcase
         drop_count <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
         if (slot_tick) begin
            if (!fifo_empty) begin
               node_in     <= 8'(head[1:0]) << {head[3:2], 1'b0};
               hub_display <= {head[5:4], head[1:0]};
            end else begin
               node_in <= '0;
            end
         end
      end
   end

endmodule
